interrupt_control_unit: RTL and testbench
=========================================

Name: interrupt_control_unit

Overview:
- Owns the pipeline control signals while the control unit (CU) floats them (`int_flag`=1).
- On an external interrupt: saves the return PC and flags to the stack, fetches the ISR address from the vector, and loads the PC.
- On an RTI decoded by the CU: pops the flags and the PC back and resumes.
- Sits beside the CU in decode; drives the memory stage and the PC/flag registers.

Parameters:
- PC_WIDTH, 32, program counter width; always 2 memory words.
- DATA_WIDTH, 16, data-memory word width.
- ADDR_WIDTH, 20, data-memory address width.
- INT_VECTOR_ADDR, 0, address of the ISR high word; low word is at +1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- intr  in  1  external interrupt request, rising-edge sensitive.
- rti  in  1  RTI decoded by the CU, one-cycle pulse.
- pc_in  in  PC_WIDTH  return address (next-instruction PC).
- flags_in  in  3  {C,N,Z} current flags.
- mem_rdata  in  DATA_WIDTH  data-memory read data, valid the cycle after DMR.
- int_flag  out  1  ICU owns control; CU outputs floated.
- stall  out  1  freeze fetch/decode.
- stack_operation  out  1  SP-addressed access.
- push_pop  out  1  1=push (pre-decrement), 0=pop.
- write_sp  out  1  update SP.
- DMR  out  1  data-memory read.
- DMW  out  1  data-memory write.
- mem_wdata  out  DATA_WIDTH  push data.
- addr_override  out  1  use mem_addr instead of SP/ALU address.
- mem_addr  out  ADDR_WIDTH  vector address.
- pc_load  out  1  load pc_out into PC.
- pc_out  out  PC_WIDTH  new PC.
- flags_load  out  1  load flags_out into flag register.
- flags_out  out  3  restored flags.

Behaviour:
- Reset (sync): state=IDLE; pending=0; intr_q=0; saved PC/flags, pc_out, flags_out=0.
- Reset: every output 0, including mem_wdata and mem_addr.
- Edge detect: pending set when intr=1 and intr_q=0; intr_q<=intr every cycle.
- pending is cleared on acceptance; a level held high is serviced once.
- Outputs are Moore-decoded from registered state.
- pc_out/flags_out are registered.
- int_flag=stall=1 in every non-IDLE state.
- Unlisted outputs are 0 in each state.
- IDLE exit priority:
  - rst.
  - rti: capture nothing -> POP_FLG.
  - pending (or the edge arriving this cycle): capture pc_in and flags_in -> PUSH_PCH.
- Interrupt sequence, 7 cycles:
  - PUSH_PCH: DMW, stack_operation, push_pop, write_sp; mem_wdata=saved_pc[31:16].
  - PUSH_PCL: same strobes; mem_wdata=saved_pc[15:0].
  - PUSH_FLG: same strobes; mem_wdata={13'b0, saved_flags}.
  - VEC_H: DMR, addr_override; mem_addr=INT_VECTOR_ADDR.
  - VEC_L: DMR, addr_override; mem_addr=INT_VECTOR_ADDR+1; capture mem_rdata as vec_hi.
  - VEC_WAIT: capture mem_rdata as vec_lo.
  - JUMP: pc_load=1; pc_out={vec_hi,vec_lo}; -> IDLE.
- RTI sequence, 5 cycles:
  - POP_FLG: DMR, stack_operation, write_sp; push_pop=0.
  - POP_PCL: pop strobes; capture mem_rdata[2:0] as flags_out.
  - POP_PCH: pop strobes; capture mem_rdata as pc_out[15:0].
  - POP_WAIT: capture mem_rdata as pc_out[31:16].
  - RESUME: pc_load=1, flags_load=1; -> IDLE.
- Boundaries:
  - intr edge during any sequence: latched in pending; serviced from IDLE.
  - Nested interrupts inside an ISR are allowed.
  - rti asserted while not IDLE: ignored.
  - rti and pending together in IDLE: RTI first; pending retained.
  - Reset mid-sequence: IDLE next cycle, pending lost, no partial pc_load.
  - mem_addr arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Reset: assert rst 2 cycles mid-run -> every output 0; int_flag=0.
- Interrupt: pc_in=0x00012345, flags_in=3'b101, mem[0]=0x0000, mem[1]=0x0200, pulse intr:
  - writes 0x0001, 0x2345, 0x0005 on cycles 1-3.
  - DMR at addr 0, then 1.
  - cycle 7: pc_load=1, pc_out=0x00000200.
  - int_flag high exactly 7 cycles.
- RTI: pulse rti with pops returning 0x0005, 0x2345, 0x0001 -> cycle 5: pc_load=flags_load=1, pc_out=0x00012345, flags_out=3'b101; push_pop=0 throughout.
- Simultaneous: rti pulse and intr edge in the same IDLE cycle -> 5-cycle RTI, then 7-cycle interrupt starting the following cycle.
- Level: intr held high 30 cycles -> exactly one interrupt sequence; a second rising edge during PUSH_FLG -> second sequence directly after JUMP.
- Reset in PUSH_PCL -> next cycle IDLE, DMW=0, no pc_load; a later intr edge is serviced normally.

Source files
------------

// File: rtl/interrupt_control_unit.sv
// Interrupt control unit.
// Takes over the pipeline control signals from the decode-stage control unit
// while it sequences an interrupt entry (push PC and flags, fetch the ISR
// vector, load PC) or an RTI (pop flags and PC, restore both).
module interrupt_control_unit #(
  parameter int          PC_WIDTH        = 32,
  parameter int          DATA_WIDTH      = 16,
  parameter int          ADDR_WIDTH      = 20,
  parameter int unsigned INT_VECTOR_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  intr,
  input  logic                  rti,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [2:0]            flags_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  int_flag,
  output logic                  stall,
  output logic                  stack_operation,
  output logic                  push_pop,
  output logic                  write_sp,
  output logic                  DMR,
  output logic                  DMW,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  addr_override,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  flags_load,
  output logic [2:0]            flags_out
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PUSH_PCH = 4'd1;
  localparam logic [3:0] S_PUSH_PCL = 4'd2;
  localparam logic [3:0] S_PUSH_FLG = 4'd3;
  localparam logic [3:0] S_VEC_H    = 4'd4;
  localparam logic [3:0] S_VEC_L    = 4'd5;
  localparam logic [3:0] S_VEC_WAIT = 4'd6;
  localparam logic [3:0] S_JUMP     = 4'd7;
  localparam logic [3:0] S_POP_FLG  = 4'd8;
  localparam logic [3:0] S_POP_PCL  = 4'd9;
  localparam logic [3:0] S_POP_PCH  = 4'd10;
  localparam logic [3:0] S_POP_WAIT = 4'd11;
  localparam logic [3:0] S_RESUME   = 4'd12;

  // Vector word addresses; the low word wraps around the top of memory.
  localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = ADDR_WIDTH'(INT_VECTOR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] VEC_LO_ADDR = VEC_HI_ADDR + ADDR_WIDTH'(1);

  logic [3:0]            state;
  logic [3:0]            state_nxt;
  logic                  intr_q;
  logic                  pending;
  logic                  intr_edge;
  logic                  accept_int;
  logic [PC_WIDTH-1:0]   saved_pc;
  logic [2:0]            saved_flags;
  logic [DATA_WIDTH-1:0] vec_hi;

  // Zero-extends the 3 flag bits to a full stack word.
  function automatic logic [DATA_WIDTH-1:0] flag_word(input logic [2:0] f);
    flag_word = {{(DATA_WIDTH-3){1'b0}}, f};
  endfunction

  assign intr_edge = intr & ~intr_q;
  // An RTI in IDLE takes priority; the interrupt stays pending behind it.
  assign accept_int = (state == S_IDLE) && !rti && (pending || intr_edge);

  // Rising-edge detection on intr; one pending request is remembered until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      intr_q <= intr;
      if (accept_int) begin
        pending <= 1'b0;
      end else if (intr_edge) begin
        pending <= 1'b1;
      end
    end
  end

  // Sequence state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: both sequences run straight through and return to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rti) begin
          state_nxt = S_POP_FLG;
        end else if (pending || intr_edge) begin
          state_nxt = S_PUSH_PCH;
        end
      end
      S_PUSH_PCH: state_nxt = S_PUSH_PCL;
      S_PUSH_PCL: state_nxt = S_PUSH_FLG;
      S_PUSH_FLG: state_nxt = S_VEC_H;
      S_VEC_H:    state_nxt = S_VEC_L;
      S_VEC_L:    state_nxt = S_VEC_WAIT;
      S_VEC_WAIT: state_nxt = S_JUMP;
      S_JUMP:     state_nxt = S_IDLE;
      S_POP_FLG:  state_nxt = S_POP_PCL;
      S_POP_PCL:  state_nxt = S_POP_PCH;
      S_POP_PCH:  state_nxt = S_POP_WAIT;
      S_POP_WAIT: state_nxt = S_RESUME;
      S_RESUME:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Return context capture and read-data capture; read data lags DMR by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      saved_pc    <= '0;
      saved_flags <= '0;
      vec_hi      <= '0;
      pc_out      <= '0;
      flags_out   <= '0;
    end else begin
      if (accept_int) begin
        saved_pc    <= pc_in;
        saved_flags <= flags_in;
      end
      case (state)
        S_VEC_L:    vec_hi <= mem_rdata;
        S_VEC_WAIT: pc_out <= {vec_hi, mem_rdata};
        S_POP_PCL:  flags_out <= mem_rdata[2:0];
        S_POP_PCH:  pc_out[DATA_WIDTH-1:0] <= mem_rdata;
        S_POP_WAIT: pc_out[PC_WIDTH-1 -: DATA_WIDTH] <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    int_flag        = (state != S_IDLE);
    stall           = (state != S_IDLE);
    stack_operation = 1'b0;
    push_pop        = 1'b0;
    write_sp        = 1'b0;
    DMR             = 1'b0;
    DMW             = 1'b0;
    mem_wdata       = '0;
    addr_override   = 1'b0;
    mem_addr        = '0;
    pc_load         = 1'b0;
    flags_load      = 1'b0;
    case (state)
      S_PUSH_PCH: begin
        DMW             = 1'b1;
        stack_operation = 1'b1;
        push_pop        = 1'b1;
        write_sp        = 1'b1;
        mem_wdata       = saved_pc[PC_WIDTH-1 -: DATA_WIDTH];
      end
      S_PUSH_PCL: begin
        DMW             = 1'b1;
        stack_operation = 1'b1;
        push_pop        = 1'b1;
        write_sp        = 1'b1;
        mem_wdata       = saved_pc[DATA_WIDTH-1:0];
      end
      S_PUSH_FLG: begin
        DMW             = 1'b1;
        stack_operation = 1'b1;
        push_pop        = 1'b1;
        write_sp        = 1'b1;
        mem_wdata       = flag_word(saved_flags);
      end
      S_VEC_H: begin
        DMR           = 1'b1;
        addr_override = 1'b1;
        mem_addr      = VEC_HI_ADDR;
      end
      S_VEC_L: begin
        DMR           = 1'b1;
        addr_override = 1'b1;
        mem_addr      = VEC_LO_ADDR;
      end
      S_JUMP: begin
        pc_load = 1'b1;
      end
      S_POP_FLG, S_POP_PCL, S_POP_PCH: begin
        DMR             = 1'b1;
        stack_operation = 1'b1;
        write_sp        = 1'b1;
      end
      S_RESUME: begin
        pc_load    = 1'b1;
        flags_load = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_control_unit.sv
// Testbench for interrupt_control_unit: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level model that expands
// each accepted interrupt or RTI into its list of expected output cycles.
module tb_interrupt_control_unit;

  logic        clk = 1'b0;
  logic        rst, intr, rti;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        int_flag, stall, stack_operation, push_pop, write_sp, DMR, DMW;
  logic [15:0] mem_wdata;
  logic        addr_override;
  logic [19:0] mem_addr;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        flags_load;
  logic [2:0]  flags_out;

  always #5 clk = ~clk;

  interrupt_control_unit #(
    .PC_WIDTH(32), .DATA_WIDTH(16), .ADDR_WIDTH(20), .INT_VECTOR_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .intr(intr), .rti(rti), .pc_in(pc_in),
    .flags_in(flags_in), .mem_rdata(mem_rdata), .int_flag(int_flag),
    .stall(stall), .stack_operation(stack_operation), .push_pop(push_pop),
    .write_sp(write_sp), .DMR(DMR), .DMW(DMW), .mem_wdata(mem_wdata),
    .addr_override(addr_override), .mem_addr(mem_addr), .pc_load(pc_load),
    .pc_out(pc_out), .flags_load(flags_load), .flags_out(flags_out)
  );

  // One expected output cycle; rdata is what memory returns during that cycle.
  typedef struct packed {
    logic        busy, so, pp, wsp, dmr, dmw, ao, pcl, fl;
    logic [15:0] wdata;
    logic [19:0] addr;
    logic [31:0] pc;
    logic [2:0]  flg;
    logic        chk_pc, chk_flg, has_rd;
    logic [15:0] rdata;
  } rec_t;

  localparam logic [19:0] VEC_A = 20'h00000;
  localparam logic [19:0] VEC_B = 20'h00001;

  rec_t        cur;
  rec_t        exp_q[$];
  logic [15:0] stk[$];
  logic        m_pend, m_intr_q;
  logic [15:0] vec_hi_val, vec_lo_val;
  bit          rand_vec;
  int          n_cmp, n_bad, cyc;
  int          nbusy, ndmw, npp, nload;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] pop_or_rand();
    if (stk.size() > 0) return stk.pop_back();
    return 16'($urandom);
  endfunction

  task automatic start_int(input logic [31:0] pc, input logic [2:0] f);
    rec_t r;
    logic [15:0] fw;
    if (rand_vec) begin
      vec_hi_val = 16'($urandom);
      vec_lo_val = 16'($urandom);
    end
    fw = {13'b0, f};
    r = '0; r.busy = 1; r.dmw = 1; r.so = 1; r.pp = 1; r.wsp = 1;
    r.wdata = pc[31:16]; exp_q.push_back(r);
    r.wdata = pc[15:0];  exp_q.push_back(r);
    r.wdata = fw;        exp_q.push_back(r);
    r = '0; r.busy = 1; r.dmr = 1; r.ao = 1; r.addr = VEC_A; exp_q.push_back(r);
    r.addr = VEC_B; r.has_rd = 1; r.rdata = vec_hi_val; exp_q.push_back(r);
    r = '0; r.busy = 1; r.has_rd = 1; r.rdata = vec_lo_val; exp_q.push_back(r);
    r = '0; r.busy = 1; r.pcl = 1; r.chk_pc = 1; r.pc = {vec_hi_val, vec_lo_val};
    exp_q.push_back(r);
    stk.push_back(pc[31:16]);
    stk.push_back(pc[15:0]);
    stk.push_back(fw);
  endtask

  task automatic start_rti();
    rec_t r;
    logic [15:0] fw, lo, hi;
    fw = pop_or_rand();
    lo = pop_or_rand();
    hi = pop_or_rand();
    r = '0; r.busy = 1; r.dmr = 1; r.so = 1; r.wsp = 1; exp_q.push_back(r);
    r.has_rd = 1; r.rdata = fw; exp_q.push_back(r);
    r.rdata = lo; exp_q.push_back(r);
    r = '0; r.busy = 1; r.has_rd = 1; r.rdata = hi; exp_q.push_back(r);
    r = '0; r.busy = 1; r.pcl = 1; r.fl = 1; r.chk_pc = 1; r.chk_flg = 1;
    r.pc = {hi, lo}; r.flg = fw[2:0];
    exp_q.push_back(r);
  endtask

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic model_advance();
    logic edge_now;
    if (rst) begin
      exp_q.delete();
      stk.delete();
      m_pend   = 1'b0;
      m_intr_q = 1'b0;
      cur = '0; cur.chk_pc = 1; cur.chk_flg = 1;
    end else begin
      edge_now = intr && !m_intr_q;
      m_intr_q = intr;
      if (!cur.busy) begin
        if (rti) begin
          start_rti();
          if (edge_now) m_pend = 1'b1;
        end else if (m_pend || edge_now) begin
          start_int(pc_in, flags_in);
          m_pend = 1'b0;
        end
      end else if (edge_now) begin
        m_pend = 1'b1;
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '0;
    end
  endtask

  task automatic check_cycle();
    cmp("ctrl", 32'({int_flag, stall, stack_operation, push_pop, write_sp, DMR, DMW,
                     addr_override, pc_load, flags_load}),
                32'({cur.busy, cur.busy, cur.so, cur.pp, cur.wsp, cur.dmr, cur.dmw,
                     cur.ao, cur.pcl, cur.fl}));
    cmp("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
    cmp("mem_addr", 32'(mem_addr), 32'(cur.addr));
    if (cur.chk_pc)  cmp("pc_out", pc_out, cur.pc);
    if (cur.chk_flg) cmp("flags_out", 32'(flags_out), 32'(cur.flg));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_advance();
    check_cycle();
    mem_rdata = cur.has_rd ? cur.rdata : 16'($urandom);
    cyc++;
  endtask

  initial begin
    rst = 1; intr = 0; rti = 0; pc_in = '0; flags_in = '0; mem_rdata = '0;
    rand_vec = 0; vec_hi_val = 16'h0000; vec_lo_val = 16'h0200;
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_pend = 0; m_intr_q = 0; cur = '0;
    step(); step();
    cmp("lit_reset_int_flag", 32'(int_flag), 32'd0);
    rst = 0;
    step();

    // Interrupt entry with known context and vector.
    pc_in = 32'h00012345; flags_in = 3'b101;
    intr = 1; step(); intr = 0;
    nbusy = 0;
    for (int i = 1; i <= 7; i++) begin
      nbusy += int'(int_flag);
      case (i)
        1: cmp("lit_wr_pch", 32'({DMW, mem_wdata}), 32'h10001);
        2: cmp("lit_wr_pcl", 32'({DMW, mem_wdata}), 32'h12345);
        3: cmp("lit_wr_flg", 32'({DMW, mem_wdata}), 32'h10005);
        4: cmp("lit_rd_vec_hi", 32'({DMR, mem_addr}), 32'h100000);
        5: cmp("lit_rd_vec_lo", 32'({DMR, mem_addr}), 32'h100001);
        7: begin
          cmp("lit_jump_load", 32'(pc_load), 32'd1);
          cmp("lit_jump_pc", pc_out, 32'h00000200);
        end
        default: ;
      endcase
      step();
    end
    cmp("lit_int_busy_cycles", 32'(nbusy), 32'd7);
    cmp("lit_idle_after_jump", 32'(int_flag), 32'd0);

    // RTI popping back the context just pushed.
    rti = 1; step(); rti = 0;
    nbusy = 0; npp = 0;
    for (int i = 1; i <= 5; i++) begin
      nbusy += int'(int_flag);
      npp   += int'(push_pop);
      if (i == 5) begin
        cmp("lit_rti_loads", 32'({pc_load, flags_load}), 32'd3);
        cmp("lit_rti_pc", pc_out, 32'h00012345);
        cmp("lit_rti_flags", 32'(flags_out), 32'd5);
      end
      step();
    end
    cmp("lit_rti_busy_cycles", 32'(nbusy), 32'd5);
    cmp("lit_rti_push_pop", 32'(npp), 32'd0);

    // Two-cycle reset in the middle of an interrupt sequence.
    intr = 1; step(); intr = 0; step(); step();
    rst = 1; step(); step();
    cmp("lit_rst_ctrl_wdata", 32'({int_flag, stall, stack_operation, push_pop, write_sp,
                                  DMR, DMW, addr_override, pc_load, flags_load, mem_wdata}), 32'd0);
    cmp("lit_rst_addr", 32'(mem_addr), 32'd0);
    cmp("lit_rst_pc", pc_out, 32'd0);
    cmp("lit_rst_flags", 32'(flags_out), 32'd0);
    rst = 0; step();

    // RTI and interrupt edge in the same idle cycle.
    rti = 1; intr = 1; step(); rti = 0; intr = 0;
    cmp("lit_sim_rti_first", 32'({DMR, stack_operation, push_pop, DMW}), 32'b1100);
    nbusy = 0; ndmw = 0;
    for (int i = 0; i < 14; i++) begin
      nbusy += int'(int_flag);
      ndmw  += int'(DMW);
      step();
    end
    cmp("lit_sim_busy_cycles", 32'(nbusy), 32'd12);
    cmp("lit_sim_pushes", 32'(ndmw), 32'd3);

    // Level held high: serviced once.
    intr = 1; nbusy = 0; ndmw = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nbusy += int'(int_flag);
      ndmw  += int'(DMW);
    end
    intr = 0; step(); step();
    cmp("lit_level_busy_cycles", 32'(nbusy), 32'd7);
    cmp("lit_level_pushes", 32'(ndmw), 32'd3);

    // Second edge arriving during PUSH_FLG queues one more sequence.
    intr = 1; step(); intr = 0; step(); step();
    cmp("lit_in_push_flg", 32'({DMW, mem_wdata[15:3]}), 32'h2000);
    intr = 1; nbusy = 0; ndmw = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      intr = 0;
      nbusy += int'(int_flag);
      ndmw  += int'(DMW);
    end
    cmp("lit_second_busy_cycles", 32'(nbusy), 32'd11);
    cmp("lit_second_pushes", 32'(ndmw), 32'd3);

    // Reset during PUSH_PCL, then a normal interrupt.
    intr = 1; step(); intr = 0; step();
    rst = 1; step();
    cmp("lit_rst_pcl_ctrl", 32'({int_flag, DMW, pc_load}), 32'd0);
    rst = 0; nload = 0; nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      nload += int'(pc_load);
      nbusy += int'(int_flag);
    end
    cmp("lit_rst_pcl_no_load", 32'(nload), 32'd0);
    cmp("lit_rst_pcl_idle", 32'(nbusy), 32'd0);
    intr = 1; step(); intr = 0;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      nbusy += int'(int_flag);
      step();
    end
    cmp("lit_after_rst_service", 32'(nbusy), 32'd7);

    // Randomized traffic.
    rand_vec = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) intr = ~intr;
      rti = ($urandom_range(0, 7) == 0);
      pc_in = $urandom;
      flags_in = 3'($urandom);
      step();
    end
    rst = 0; rti = 0; intr = 0;
    for (int i = 0; i < 20; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
